inference_sequencer: RTL and testbench
======================================

// Module: inference_sequencer
// PURPOSE
//  Top-level controller for the Inference datapath. Loads the A (inputs), B (hidden weights) and C (output weights) RAMs from one AXI-Stream slave.
//  Fires a single Start pulse into Inference, then waits for its Done.
//  Finally reads the RES RAM and streams the results out on an AXI-Stream master.
//  Sits between the AXI-Stream coprocessor shell and Inference plus its RAMs.
// PARAMETERS
//  width          8     bits per data word / RAM location
//  A_depth_bits   9     A RAM address width
//  B_depth_bits   4     B RAM address width
//  C_depth_bits   2     C RAM address width
//  RES_depth_bits 6     RES RAM address width
//  NUM_A          448   words loaded into A (64 datapoints x 7 features)
//  NUM_B          16    words loaded into B (8 rows x 2, row 0 = bias)
//  NUM_C          3     words loaded into C (row 0 = bias)
//  NUM_RES        64    result words streamed out
//  WDOG_CYCLES    4096  compute watchdog limit (WATCHDOG_EN only)
// PORTS
//  clk                 in   1               clock, all logic on rising edge
//  resetn              in   1               asynchronous, active-low reset
//  S_AXIS_TDATA        in   width           input stream data
//  S_AXIS_TVALID       in   1               input stream valid
//  S_AXIS_TREADY       out  1               input stream ready
//  S_AXIS_TLAST        in   1               input stream last
//  M_AXIS_TDATA        out  width           output stream data
//  M_AXIS_TVALID       out  1               output stream valid
//  M_AXIS_TREADY       in   1               output stream ready
//  M_AXIS_TLAST        out  1               output stream last
//  A_write_en/_address/_data_in  out 1/A_depth_bits/width    A RAM write port
//  B_write_en/_address/_data_in  out 1/B_depth_bits/width    B RAM write port
//  C_write_en/_address/_data_in  out 1/C_depth_bits/width    C RAM write port
//  inf_start           out  1               one-cycle Start pulse to Inference
//  inf_done            in   1               Done pulse from Inference
//  RES_read_en         out  1               RES RAM read enable
//  RES_read_address    out  RES_depth_bits  RES RAM read address
//  RES_read_data_out   in   width           RES RAM data, valid 1 cycle after read_en
//  busy                out  1               high in any state except IDLE
//  err_tlast           out  1               sticky: TLAST seen before final input word
//  err_timeout         out  1               sticky: watchdog expired (0 without WATCHDOG_EN)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; word counter=0; all outputs 0, including both sticky errors.
//  FSM: IDLE -> LOAD_A -> LOAD_B -> LOAD_C -> COMPUTE -> SEND_RD <-> SEND_OUT -> IDLE.
//  IDLE: S_AXIS_TREADY=0. Moves to LOAD_A when S_AXIS_TVALID=1. Sticky errors clear on leaving IDLE.
//  LOAD_x: S_AXIS_TREADY=1.
//   - Each TVALID&TREADY handshake drives x_write_en=1, address=counter, data=TDATA in the same cycle (combinational write).
//   - On the NUM_x-th handshake, the counter resets to 0 and the FSM advances to the next state.
//  TLAST handling:
//   - TLAST on any handshake other than word NUM_A+NUM_B+NUM_C sets err_tlast.
//   - Loading continues regardless.
//   - TLAST missing on the final word is not an error.
//  COMPUTE: S_AXIS_TREADY=0.
//   - inf_start=1 for exactly the first cycle in COMPUTE, i.e. one cycle after the last C write.
//   - inf_done moves the FSM to SEND_RD. inf_done in any other state is ignored.
//  SEND_RD: RES_read_en=1, RES_read_address=counter; -> SEND_OUT next cycle.
//  SEND_OUT:
//   - M_AXIS_TDATA is registered from RES_read_data_out on entry and held stable with TVALID=1 until TREADY.
//   - M_AXIS_TLAST=1 iff counter==NUM_RES-1.
//   - Handshake on a non-last word: counter++, -> SEND_RD.
//   - Handshake on the last word: counter=0, -> IDLE.
//   - Throughput: 2 cycles/word minimum.
//  Backpressure: TVALID is never withdrawn before TREADY. TDATA/TLAST do not change while TVALID & !TREADY.
//  Counter is clog2(NUM_A)+1 bits and never wraps inside a phase.
// CONFIGURATION
//  `define WATCHDOG_EN
//   - A cycle counter starts at 0 when COMPUTE is entered.
//   - If it reaches WDOG_CYCLES with no inf_done: err_timeout=1, FSM -> IDLE, no output words sent.
//  Without WATCHDOG_EN: COMPUTE waits indefinitely; err_timeout is tied to 0.
// TESTING
//  1 Stream 467 words (value=index mod 256), TLAST on 467th.
//    -> A writes addr 0..447, B 0..15, C 0..2.
//    -> inf_start high exactly 1 cycle, 1 cycle after C addr 2 write.
//    -> err_tlast=0.
//  2 After test 1, pulse inf_done with RES model holding RES[i]=i+1.
//    -> 64 output words 1..64; TLAST only on word 64; busy drops the cycle after the last handshake.
//  3 M_AXIS_TREADY toggled at random (50%) during test 2.
//    -> identical data sequence; TDATA stable while TVALID&!TREADY.
//  4 TLAST asserted on input word 10.
//    -> err_tlast=1; loading completes all 467 writes; err_tlast clears on the next frame start.
//  5 resetn dropped while in SEND_OUT at word 30.
//    -> outputs 0 immediately, state IDLE.
//    -> a following full frame produces 64 words from address 0.
//  6 WATCHDOG_EN, WDOG_CYCLES=100, no inf_done.
//    -> err_timeout=1 at cycle 100 of COMPUTE, FSM back to IDLE, M_AXIS_TVALID never asserted.

Source files
------------

// File: rtl/inference_sequencer.sv
// inference_sequencer: loads A/B/C RAMs from one AXI-Stream slave, pulses Inference start, streams RES out.
module inference_sequencer #(
  parameter int width = 8,
  parameter int A_depth_bits = 9,
  parameter int B_depth_bits = 4,
  parameter int C_depth_bits = 2,
  parameter int RES_depth_bits = 6,
  parameter int NUM_A = 448,
  parameter int NUM_B = 16,
  parameter int NUM_C = 3,
  parameter int NUM_RES = 64,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [width-1:0]          S_AXIS_TDATA,
  input  logic                      S_AXIS_TVALID,
  output logic                      S_AXIS_TREADY,
  input  logic                      S_AXIS_TLAST,
  output logic [width-1:0]          M_AXIS_TDATA,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY,
  output logic                      M_AXIS_TLAST,
  output logic                      A_write_en,
  output logic [A_depth_bits-1:0]   A_write_address,
  output logic [width-1:0]          A_write_data_in,
  output logic                      B_write_en,
  output logic [B_depth_bits-1:0]   B_write_address,
  output logic [width-1:0]          B_write_data_in,
  output logic                      C_write_en,
  output logic [C_depth_bits-1:0]   C_write_address,
  output logic [width-1:0]          C_write_data_in,
  output logic                      inf_start,
  input  logic                      inf_done,
  output logic                      RES_read_en,
  output logic [RES_depth_bits-1:0] RES_read_address,
  input  logic [width-1:0]          RES_read_data_out,
  output logic                      busy,
  output logic                      err_tlast,
  output logic                      err_timeout
);
  localparam int CW = $clog2(NUM_A) + 1;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LOAD_C, COMPUTE, SEND_RD, SEND_OUT} state_t;
  state_t state, next;
  logic [CW-1:0] cnt, cnt_next;
  logic [width-1:0] hold;
  logic fresh, hs, last_word, timeout, frame_start;
  assign S_AXIS_TREADY = state inside {LOAD_A, LOAD_B, LOAD_C};
  assign hs = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_word = state == LOAD_C && cnt == CW'(NUM_C - 1);
  assign frame_start = state == IDLE && S_AXIS_TVALID;
  assign busy = state != IDLE;
  assign A_write_en = state == LOAD_A && S_AXIS_TVALID;
  assign B_write_en = state == LOAD_B && S_AXIS_TVALID;
  assign C_write_en = state == LOAD_C && S_AXIS_TVALID;
  assign A_write_address = A_write_en ? cnt[A_depth_bits-1:0] : '0;
  assign B_write_address = B_write_en ? cnt[B_depth_bits-1:0] : '0;
  assign C_write_address = C_write_en ? cnt[C_depth_bits-1:0] : '0;
  assign A_write_data_in = A_write_en ? S_AXIS_TDATA : '0;
  assign B_write_data_in = B_write_en ? S_AXIS_TDATA : '0;
  assign C_write_data_in = C_write_en ? S_AXIS_TDATA : '0;
  assign RES_read_en = state == SEND_RD;
  assign RES_read_address = RES_read_en ? cnt[RES_depth_bits-1:0] : '0;
  assign M_AXIS_TVALID = state == SEND_OUT;
  assign M_AXIS_TLAST = M_AXIS_TVALID && cnt == CW'(NUM_RES - 1);
  assign M_AXIS_TDATA = !M_AXIS_TVALID ? '0 : fresh ? RES_read_data_out : hold;
  always_comb begin
    next = state;
    cnt_next = cnt;
    case (state)
      IDLE: if (S_AXIS_TVALID) next = LOAD_A;
      LOAD_A: if (hs) begin
        next = cnt == CW'(NUM_A - 1) ? LOAD_B : LOAD_A;
        cnt_next = cnt == CW'(NUM_A - 1) ? '0 : cnt + 1'b1;
      end
      LOAD_B: if (hs) begin
        next = cnt == CW'(NUM_B - 1) ? LOAD_C : LOAD_B;
        cnt_next = cnt == CW'(NUM_B - 1) ? '0 : cnt + 1'b1;
      end
      LOAD_C: if (hs) begin
        next = last_word ? COMPUTE : LOAD_C;
        cnt_next = last_word ? '0 : cnt + 1'b1;
      end
      COMPUTE: next = inf_done ? SEND_RD : timeout ? IDLE : COMPUTE;
      SEND_RD: next = SEND_OUT;
      SEND_OUT: if (M_AXIS_TREADY) begin
        next = M_AXIS_TLAST ? IDLE : SEND_RD;
        cnt_next = M_AXIS_TLAST ? '0 : cnt + 1'b1;
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      hold <= '0;
      fresh <= 1'b0;
      inf_start <= 1'b0;
      err_tlast <= 1'b0;
    end else begin
      state <= next;
      cnt <= cnt_next;
      fresh <= state == SEND_RD;
      hold <= fresh ? RES_read_data_out : hold;
      inf_start <= hs && last_word;
      err_tlast <= frame_start ? 1'b0 : (hs && S_AXIS_TLAST && !last_word) ? 1'b1 : err_tlast;
    end
  end
`ifdef WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog;
  assign timeout = state == COMPUTE && !inf_done && wdog == WW'(WDOG_CYCLES - 1);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wdog <= '0;
      err_timeout <= 1'b0;
    end else begin
      wdog <= state == COMPUTE ? wdog + 1'b1 : '0;
      err_timeout <= timeout ? 1'b1 : frame_start ? 1'b0 : err_timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: directed bench for inference_sequencer (define WATCHDOG_EN to run the watchdog scenario).
module tb_inference_sequencer;
  logic clk = 1'b0, resetn;
  logic [7:0] S_AXIS_TDATA, M_AXIS_TDATA, A_write_data_in, B_write_data_in, C_write_data_in, RES_read_data_out;
  logic S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST, M_AXIS_TVALID, M_AXIS_TREADY, M_AXIS_TLAST;
  logic A_write_en, B_write_en, C_write_en, inf_start, inf_done, RES_read_en, busy, err_tlast, err_timeout;
  logic [8:0] A_write_address;
  logic [3:0] B_write_address;
  logic [1:0] C_write_address;
  logic [5:0] RES_read_address;
  logic [7:0] res_q = 8'd0;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (RES_read_en) res_q <= 8'(RES_read_address) + 8'd1;
  assign RES_read_data_out = res_q;

  inference_sequencer #(.WDOG_CYCLES(100)) dut (
    .clk(clk), .resetn(resetn),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
    .A_write_en(A_write_en), .A_write_address(A_write_address), .A_write_data_in(A_write_data_in),
    .B_write_en(B_write_en), .B_write_address(B_write_address), .B_write_data_in(B_write_data_in),
    .C_write_en(C_write_en), .C_write_address(C_write_address), .C_write_data_in(C_write_data_in),
    .inf_start(inf_start), .inf_done(inf_done),
    .RES_read_en(RES_read_en), .RES_read_address(RES_read_address), .RES_read_data_out(RES_read_data_out),
    .busy(busy), .err_tlast(err_tlast), .err_timeout(err_timeout)
  );

  task automatic send_frame(input int tl);
    int k = 0, cyc = 0, ea, oa;
    logic [2:0] en_e;
    logic [7:0] od;
    S_AXIS_TVALID = 1'b1;
    while (k < 467 && cyc < 2000) begin
      S_AXIS_TDATA = 8'(k);
      S_AXIS_TLAST = (k == tl);
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        checks++;
        if ({S_AXIS_TREADY, busy} !== 2'b00) begin
          errors++;
          $display("FAIL idle_ready got ready=%b busy=%b want 0 0", S_AXIS_TREADY, busy);
        end
      end
      if (S_AXIS_TREADY) begin
        if (k == 0) begin
          checks++;
          if ({err_tlast, err_timeout} !== 2'b00) begin
            errors++;
            $display("FAIL err_clear got tlast=%b timeout=%b want 0 0", err_tlast, err_timeout);
          end
        end
        en_e = k < 448 ? 3'b100 : k < 464 ? 3'b010 : 3'b001;
        ea = k < 448 ? k : k < 464 ? k - 448 : k - 464;
        oa = k < 448 ? int'(A_write_address) : k < 464 ? int'(B_write_address) : int'(C_write_address);
        od = k < 448 ? A_write_data_in : k < 464 ? B_write_data_in : C_write_data_in;
        checks++;
        if ({A_write_en, B_write_en, C_write_en, inf_start} !== {en_e, 1'b0} || oa != ea || od !== 8'(k)) begin
          errors++;
          $display("FAIL write word %0d got en=%b%b%b start=%b addr=%0d data=%h want en=%b start=0 addr=%0d data=%h",
                   k, A_write_en, B_write_en, C_write_en, inf_start, oa, od, en_e, ea, 8'(k));
        end
        k++;
      end
      @(posedge clk);
      #1;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    checks++;
    if (k != 467) begin
      errors++;
      $display("FAIL load_count got %0d want 467", k);
    end
    @(negedge clk);
    checks++;
    if ({inf_start, busy, S_AXIS_TREADY} !== 3'b110) begin
      errors++;
      $display("FAIL start_pulse got start=%b busy=%b ready=%b want 1 1 0", inf_start, busy, S_AXIS_TREADY);
    end
    @(negedge clk);
    checks++;
    if (inf_start !== 1'b0) begin
      errors++;
      $display("FAIL start_width got %b want 0", inf_start);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, M_AXIS_TVALID, RES_read_en} !== 3'b100) begin
      errors++;
      $display("FAIL compute_wait got busy=%b tvalid=%b rd=%b want 1 0 0", busy, M_AXIS_TVALID, RES_read_en);
    end
    @(posedge clk);
    #1 inf_done = 1'b1;
    @(posedge clk);
    #1 inf_done = 1'b0;
  endtask

  task automatic recv(input bit rnd, input int stop_at);
    int n = 0, cyc = 0;
    bit stalled = 0;
    logic [7:0] prev = 8'd0;
    while (n < stop_at && cyc < 3000) begin
      M_AXIS_TREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++;
      if (M_AXIS_TVALID) begin
        checks++;
        if ({M_AXIS_TDATA, M_AXIS_TLAST} !== {8'(n + 1), n == 63} || (stalled && M_AXIS_TDATA !== prev)) begin
          errors++;
          $display("FAIL out word %0d got data=%h last=%b want data=%h last=%b", n, M_AXIS_TDATA, M_AXIS_TLAST, 8'(n + 1), n == 63);
        end
        stalled = !M_AXIS_TREADY;
        prev = M_AXIS_TDATA;
        if (M_AXIS_TREADY) n++;
      end
      @(posedge clk);
      #1;
    end
    M_AXIS_TREADY = 1'b0;
    checks++;
    if (n != stop_at) begin
      errors++;
      $display("FAIL out_count got %0d want %0d", n, stop_at);
    end
    if (stop_at == 64) begin
      @(negedge clk);
      checks++;
      if ({busy, M_AXIS_TVALID} !== 2'b00) begin
        errors++;
        $display("FAIL busy_drop got busy=%b tvalid=%b want 0 0", busy, M_AXIS_TVALID);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    S_AXIS_TVALID = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({S_AXIS_TREADY, M_AXIS_TDATA, M_AXIS_TVALID, M_AXIS_TLAST, A_write_en, A_write_address, A_write_data_in,
         B_write_en, B_write_address, B_write_data_in, C_write_en, C_write_address, C_write_data_in,
         inf_start, RES_read_en, RES_read_address, busy, err_tlast, err_timeout} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got nonzero outputs busy=%b ready=%b aen=%b want all 0", busy, S_AXIS_TREADY, A_write_en);
    end
    S_AXIS_TVALID = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1 inf_done = 1'b1;
    @(posedge clk);
    #1 inf_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, S_AXIS_TREADY, RES_read_en} !== 3'b000) begin
      errors++;
      $display("FAIL done_in_idle got busy=%b ready=%b rd=%b want 0 0 0", busy, S_AXIS_TREADY, RES_read_en);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_load_and_stream();
    send_frame(466);
    checks++;
    if (err_tlast !== 1'b0) begin
      errors++;
      $display("FAIL tlast_ok got %b want 0", err_tlast);
    end
    pulse_done();
    recv(0, 64);
  endtask

  task automatic test_backpressure();
    send_frame(466);
    pulse_done();
    recv(1, 64);
  endtask

  task automatic test_tlast_early();
    send_frame(9);
    checks++;
    if (err_tlast !== 1'b1) begin
      errors++;
      $display("FAIL tlast_early got %b want 1", err_tlast);
    end
    pulse_done();
    recv(0, 64);
    checks++;
    if (err_tlast !== 1'b1) begin
      errors++;
      $display("FAIL tlast_sticky got %b want 1", err_tlast);
    end
    send_frame(466);
    pulse_done();
    recv(0, 64);
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    send_frame(466);
    pulse_done();
    recv(0, 30);
    M_AXIS_TREADY = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!M_AXIS_TVALID && cyc < 10);
    checks++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA} !== {1'b1, 8'd31}) begin
      errors++;
      $display("FAIL word30 got valid=%b data=%h want 1 1f", M_AXIS_TVALID, M_AXIS_TDATA);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if ({M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, busy, RES_read_en, S_AXIS_TREADY} !== '0) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h busy=%b want 0 00 0", M_AXIS_TVALID, M_AXIS_TDATA, busy);
    end
    @(posedge clk);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;
    send_frame(466);
    pulse_done();
    recv(0, 64);
  endtask

  task automatic test_watchdog();
    int bad = 0;
    send_frame(466);
`ifdef WATCHDOG_EN
    for (int i = 3; i <= 100; i++) begin
      @(negedge clk);
      if (!busy || err_timeout || M_AXIS_TVALID) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wdog_early got %0d bad cycles want 0", bad);
    end
    @(negedge clk);
    checks++;
    if ({busy, err_timeout} !== 2'b01) begin
      errors++;
      $display("FAIL wdog_expire got busy=%b timeout=%b want 0 1", busy, err_timeout);
    end
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (M_AXIS_TVALID || busy) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wdog_no_output got %0d bad cycles want 0", bad);
    end
    @(posedge clk);
    #1;
    send_frame(466);
    pulse_done();
    recv(0, 64);
`else
    repeat (150) begin
      @(negedge clk);
      if (!busy || err_timeout || M_AXIS_TVALID) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL compute_hold got %0d bad cycles want 0", bad);
    end
    @(posedge clk);
    #1;
    pulse_done();
    recv(0, 64);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    S_AXIS_TDATA = 8'd0;
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST = 1'b0;
    M_AXIS_TREADY = 1'b0;
    inf_done = 1'b0;
    test_reset();
    test_load_and_stream();
    test_backpressure();
    test_tlast_early();
    test_reset_mid();
    test_watchdog();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
